// File: rtl/boid_render_pkg.sv
// Shared types and default geometry for the boid frame renderer.
package boid_render_pkg;

  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_FRAC_BITS = 16;

  localparam logic [7:0] DEF_BOID_COLOR = 8'hFF;
  localparam logic [7:0] DEF_BG_COLOR   = 8'h00;

  typedef logic [DEF_ADDR_W-1:0] pix_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CALC,
    ERASE,
    DRAW,
    DONE
  } render_state_t;

endpackage

// File: rtl/boid_frame_renderer_pos_to_addr.sv
// Fixed-point boid position to linear VGA pixel address, with on-screen check.
module boid_pos_to_addr
  import boid_render_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic signed [31:0]       x,
  input  logic signed [31:0]       y,
  output logic                     new_ok,
  output logic        [ADDR_W-1:0] new_addr
);

  logic signed [31:0] xi;
  logic signed [31:0] yi;

  // Drop the fraction (keeping sign), bounds-check, and linearise row-major.
  always_comb begin
    xi       = x >>> FRAC_BITS;
    yi       = y >>> FRAC_BITS;
    new_ok   = (xi >= 0) && (xi < H_RES) && (yi >= 0) && (yi < V_RES);
    new_addr = ADDR_W'(yi * H_RES + xi);
  end

endmodule

// File: rtl/boid_frame_renderer.sv
// Per-frame boid renderer: reads each boid position, erases its stale pixel
// and draws the new one through a valid/ready pixel-write port.
module boid_frame_renderer
  import boid_render_pkg::*;
#(
  parameter int         NUM_BOIDS  = 2,
  parameter int         H_RES      = DEF_H_RES,
  parameter int         V_RES      = DEF_V_RES,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter int         FRAC_BITS  = DEF_FRAC_BITS,
  parameter logic [7:0] BOID_COLOR = DEF_BOID_COLOR,
  parameter logic [7:0] BG_COLOR   = DEF_BG_COLOR,
  localparam int        CNT_W      = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     is_refilling,
  output logic        [CNT_W-1:0]  which_boid,
  input  logic signed [31:0]       x_in,
  input  logic signed [31:0]       y_in,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic        [ADDR_W-1:0] pix_addr,
  output logic        [7:0]        pix_color,
  output logic                     busy,
  output logic                     done
);

  render_state_t state, state_next;

  logic        [CNT_W-1:0]  cnt;
  logic signed [31:0]       x_r, y_r;
  logic                     calc_ok, ok_r;
  logic        [ADDR_W-1:0] calc_addr, addr_r;
  logic        [ADDR_W-1:0] old_addr [NUM_BOIDS];
  logic        [NUM_BOIDS-1:0] old_valid;

  logic last_boid, erase_req;
  logic load_pos, load_calc, commit, cnt_clear, cnt_inc;

  boid_pos_to_addr #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .ADDR_W   (ADDR_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_pos_to_addr (
    .x       (x_r),
    .y       (y_r),
    .new_ok  (calc_ok),
    .new_addr(calc_addr)
  );

  assign which_boid = cnt;
  assign last_boid  = (cnt == CNT_W'(NUM_BOIDS - 1));
  // A stale pixel needs erasing unless the boid is redrawn on the very same spot.
  assign erase_req  = old_valid[cnt] && !(ok_r && (old_addr[cnt] == addr_r));

  // State, boid counter and table-valid bits; reset aborts the frame at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      old_valid <= '0;
    end else begin
      state <= state_next;
      if (cnt_clear)    cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (commit) old_valid[cnt] <= ok_r;
    end
  end

  // Position/address pipeline and last-drawn address table.
  always_ff @(posedge clk) begin
    // NOTE: the address table is deliberately not reset; old_valid alone
    // decides whether an entry is meaningful, so clearing it is enough.
    if (load_pos) begin
      x_r <= x_in;
      y_r <= y_in;
    end
    if (load_calc) begin
      ok_r   <= calc_ok;
      addr_r <= calc_addr;
    end
    if (commit) old_addr[cnt] <= addr_r;
  end

  // Next-state and handshake outputs; pixel requests only in ERASE/DRAW.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next = state;
    pix_valid  = 1'b0;
    pix_addr   = '0;
    pix_color  = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    load_pos   = 1'b0;
    load_calc  = 1'b0;
    commit     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT;
          cnt_clear  = 1'b1;
        end
      end
      WAIT:  if (!is_refilling) state_next = READ;
      READ: begin
        load_pos   = 1'b1;
        state_next = CALC;
      end
      CALC: begin
        load_calc  = 1'b1;
        state_next = ERASE;
      end
      ERASE: begin
        if (erase_req) begin
          pix_valid = 1'b1;
          pix_addr  = old_addr[cnt];
          pix_color = BG_COLOR;
          if (pix_ready) state_next = DRAW;
        end else begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (ok_r) begin
          pix_valid = 1'b1;
          pix_addr  = addr_r;
          pix_color = BOID_COLOR;
        end
        if (!ok_r || pix_ready) begin
          commit = 1'b1;
          if (last_boid) begin
            state_next = DONE;
          end else begin
            state_next = READ;
            cnt_inc    = 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boid_frame_renderer.sv
// Self-checking bench: frame-level reference model of erase/draw traffic,
// per-cycle transfer/handshake monitor, directed cases and random frames.
module tb_boid_frame_renderer;

  localparam int NB    = 2;
  localparam int HRES  = 640;
  localparam int VRES  = 480;
  localparam int ONE   = 65536;

  logic        clk = 1'b0;
  logic        reset, start, is_refilling, pix_ready;
  logic [0:0]  which_boid;
  logic signed [31:0] x_in, y_in;
  logic        pix_valid;
  logic [18:0] pix_addr;
  logic [7:0]  pix_color;
  logic        busy, done;

  int bx [NB];
  int by [NB];

  // Boid state memory: combinational read through which_boid.
  assign x_in = bx[which_boid];
  assign y_in = by[which_boid];

  always #5 clk = ~clk;

  boid_frame_renderer #(.NUM_BOIDS(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_refilling(is_refilling),
    .which_boid  (which_boid),
    .x_in        (x_in),
    .y_in        (y_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_addr    (pix_addr),
    .pix_color   (pix_color),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what is on screen per boid, and the expected write stream.
  bit mv [NB];
  int ma [NB];
  int exp_addr [$];
  int exp_col  [$];
  int cap_addr [$];
  int cap_col  [$];

  int ready_mode = 0;  // 0 high, 1 random, 2 stall draws, 3 low
  int stall_left = 0;
  int stall_seen = 0;

  bit          prev_stall = 1'b0;
  logic [18:0] prev_addr;
  logic [7:0]  prev_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: hold-while-stalled, and every transfer against the model.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", pix_valid, 1);
        check("hold_addr", pix_addr, prev_addr);
        check("hold_color", pix_color, prev_col);
      end
      if (pix_valid) check("valid_implies_busy", busy, 1);
      if (pix_valid && !pix_ready) stall_seen++;
      if (pix_valid && pix_ready) begin
        cap_addr.push_back(int'(pix_addr));
        cap_col.push_back(int'(pix_color));
        check("xfer_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) begin
          check("xfer_addr", pix_addr, exp_addr.pop_front());
          check("xfer_color", pix_color, exp_col.pop_front());
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_addr  = pix_addr;
      prev_col   = pix_color;
    end
  end

  // Writer-side ready generator, updated just after each rising edge.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom_range(0, 1));
        2: begin
          if (pix_valid && pix_color == 8'hFF && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
          end else begin
            pix_ready = 1'b1;
          end
        end
        default: pix_ready = 1'b0;
      endcase
    end
  end

  // Build the frame's expected writes from the positions, then run it.
  task automatic run_frame(input int refill_cycles, input bit chk_cycles, input string tag);
    int cyc;
    bit got;
    exp_addr.delete();
    exp_col.delete();
    for (int i = 0; i < NB; i++) begin
      int xi, yi, addr;
      bit ok;
      xi   = bx[i] >>> 16;
      yi   = by[i] >>> 16;
      ok   = (xi >= 0) && (xi < HRES) && (yi >= 0) && (yi < VRES);
      addr = (yi * HRES + xi) & 32'h7FFFF;
      if (mv[i] && !(ok && ma[i] == addr)) begin
        exp_addr.push_back(ma[i]);
        exp_col.push_back(0);
      end
      if (ok) begin
        exp_addr.push_back(addr);
        exp_col.push_back(255);
      end
      mv[i] = ok;
      ma[i] = addr;
    end
    cap_addr.delete();
    cap_col.delete();
    stall_seen   = 0;
    is_refilling = (refill_cycles > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (refill_cycles > 0) begin
      for (int k = 0; k < refill_cycles; k++) begin
        @(negedge clk);
        check({tag, "_refill_boid"}, which_boid, 0);
        check({tag, "_refill_novalid"}, pix_valid, 0);
      end
      tick();
      is_refilling = 1'b0;
    end
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) cyc++;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_queue_drained"}, exp_addr.size(), 0);
    if (chk_cycles) check({tag, "_cycles"}, cyc, 1 + 4 * NB);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  function automatic int rand_coord(input int res);
    int v;
    case ($urandom_range(0, 6))
      0, 1, 2: v = int'($urandom_range(0, res - 1));
      3:       v = -int'($urandom_range(1, 50));
      4:       v = res + int'($urandom_range(0, 50));
      5:       v = res - 1;
      default: v = 0;
    endcase
    return v * ONE + int'($urandom_range(0, ONE - 1));
  endfunction

  initial begin
    bit seen;
    int n_bg;
    reset = 1'b1;
    start = 1'b0;
    is_refilling = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bx[i] = 0;
      by[i] = 0;
      mv[i] = 1'b0;
      ma[i] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_which_boid", which_boid, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_addr", pix_addr, 0);
    check("rst_pix_color", pix_color, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();

    // Boid 1 parked off-screen so the directed frames show only boid 0 traffic.
    bx[1] = 700 * ONE;
    by[1] = 10 * ONE;

    bx[0] = 100 * ONE; by[0] = 100 * ONE;
    run_frame(0, 1, "f1");
    check("f1_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check("f1_draw_addr", cap_addr[0], 64100);
      check("f1_draw_col", cap_col[0], 255);
    end

    bx[0] = 110 * ONE;
    run_frame(0, 1, "f2");
    check("f2_count", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      check("f2_erase_addr", cap_addr[0], 64100);
      check("f2_erase_col", cap_col[0], 0);
      check("f2_draw_addr", cap_addr[1], 64110);
      check("f2_draw_col", cap_col[1], 255);
    end

    run_frame(0, 1, "f3");
    check("f3_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check("f3_draw_addr", cap_addr[0], 64110);
      check("f3_draw_col", cap_col[0], 255);
    end

    bx[0] = -5 * ONE;
    run_frame(0, 1, "f4");
    check("f4_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      check("f4_erase_addr", cap_addr[0], 64110);
      check("f4_erase_col", cap_col[0], 0);
    end

    run_frame(0, 1, "f5");
    check("f5_count", cap_addr.size(), 0);

    // Writer stalls the draw for five cycles.
    ready_mode = 2;
    stall_left = 5;
    bx[0] = 200 * ONE; by[0] = 50 * ONE;
    run_frame(0, 0, "stall");
    check("stall_cycles", stall_seen, 5);
    check("stall_count", cap_addr.size(), 1);
    if (cap_addr.size() == 1) check("stall_addr", cap_addr[0], 32200);

    // Memory still refilling when start arrives.
    ready_mode = 0;
    bx[0] = 10 * ONE; by[0] = 20 * ONE;
    run_frame(10, 0, "refill");
    check("refill_count", cap_addr.size(), 2);

    // Reset while an erase is stalled.
    ready_mode = 3;
    bx[0] = 11 * ONE;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pix_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_erase_seen", seen, 1);
    check("rst_mid_erase_addr", pix_addr, 12810);
    check("rst_mid_erase_col", pix_color, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", pix_valid, 0);
    check("rst_mid_busy", busy, 0);
    for (int i = 0; i < NB; i++) mv[i] = 1'b0;
    ready_mode = 0;
    tick();
    run_frame(0, 1, "post_rst");
    n_bg = 0;
    foreach (cap_col[i]) if (cap_col[i] == 0) n_bg++;
    check("post_rst_no_erase", n_bg, 0);
    check("post_rst_count", cap_addr.size(), 1);

    // Random frames with random writer back-pressure and refill delays.
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          bx[i] = rand_coord(HRES);
          by[i] = rand_coord(VRES);
        end
      end
      run_frame(int'($urandom_range(0, 3)), 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
